// File: rtl/logic_sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } sweep_state_e;

  localparam int unsigned DefNIn   = 4;
  localparam int unsigned DefSettle = 1;

  // Number of truth-table entries for an n-input function.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/logic_sweep_settle_cnt.sv
// Settle counter: loads SETTLE, counts down while enabled, flags zero.
module logic_sweep_settle_cnt #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CntW'(SETTLE);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/logic_tt_sweeper.sv
// Drives every input vector onto a logic cell and captures its output as a truth table.
// Optional feature: define TT_COMPARE_EN to add expected-table comparison ports.
module logic_tt_sweeper
  import logic_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned SETTLE = DefSettle,
  localparam int unsigned TtW   = tt_width(N_IN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            fn_in_i,
  output logic [N_IN-1:0] vec_out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [TtW-1:0]  tt_out_o,
  output logic            tt_valid_o
`ifdef TT_COMPARE_EN
  ,
  input  logic [TtW-1:0]  exp_tt_i,
  output logic            mismatch_o,
  output logic [N_IN-1:0] fail_idx_o
`endif
);

  localparam int unsigned IdxW = $clog2(TtW);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TtW - 1);

  sweep_state_e    state_q;
  logic [IdxW-1:0] idx_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q, done_q, tt_valid_q;
  logic [TtW-1:0]  shadow_q, tt_q, shadow_smp;

  logic cnt_zero, cnt_load, cnt_en, cnt_clr;
  logic accept, sample, last;

  assign accept   = (state_q == ST_IDLE) && start_i;
  // Abort outranks the sample that would otherwise happen this cycle.
  assign sample   = (state_q == ST_WAIT) && !abort_i && cnt_zero;
  assign last     = (idx_q == LastIdx);
  assign cnt_load = accept || (sample && !last);
  assign cnt_en   = (state_q == ST_WAIT);
  assign cnt_clr  = (state_q == ST_WAIT) && abort_i;

  always_comb begin
    shadow_smp        = shadow_q;
    shadow_smp[idx_q] = fn_in_i;
  end

  logic_sweep_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .zero_o(cnt_zero)
  );

`ifdef TT_COMPARE_EN
  logic            mismatch_q;
  logic [N_IN-1:0] fail_idx_q, first_diff;
  logic [TtW-1:0]  diff;

  always_comb begin
    diff       = shadow_smp ^ exp_tt_i;
    first_diff = '0;
    for (int i = TtW - 1; i >= 0; i--) begin
      if (diff[i]) first_diff = N_IN'(i);
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shadow_q   <= '0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
`ifdef TT_COMPARE_EN
      mismatch_q <= 1'b0;
      fail_idx_q <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          vec_q  <= '0;
          if (accept) begin
            state_q    <= ST_WAIT;
            idx_q      <= '0;
            shadow_q   <= '0;
            tt_valid_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef TT_COMPARE_EN
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
          end else if (sample) begin
            shadow_q <= shadow_smp;
            if (last) begin
              state_q    <= ST_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              tt_q       <= shadow_smp;
              tt_valid_q <= 1'b1;
`ifdef TT_COMPARE_EN
              mismatch_q <= (shadow_smp != exp_tt_i);
              fail_idx_q <= first_diff;
`endif
            end else begin
              idx_q <= idx_q + IdxW'(1);
              vec_q <= N_IN'(idx_q + IdxW'(1));
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          vec_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          vec_q   <= '0;
        end
      endcase
    end
  end

  assign vec_out_o  = vec_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tt_out_o   = tt_q;
  assign tt_valid_o = tt_valid_q;
`ifdef TT_COMPARE_EN
  assign mismatch_o = mismatch_q;
  assign fail_idx_o = fail_idx_q;
`endif

endmodule

// File: tb/tb_logic_tt_sweeper.sv
// Bench for logic_tt_sweeper: two instances (SETTLE=0 and SETTLE=1) against a table model.
module tb_logic_tt_sweeper;

  logic clk, rst;
  logic [1:0]       start, abort, fn_in, busy, done, tt_valid;
  logic [1:0][3:0]  vec;
  logic [1:0][15:0] tt;
  logic [1:0][15:0] tbl;
  logic [1:0][15:0] m_tt;
  logic [1:0]       m_valid;
`ifdef TT_COMPARE_EN
  logic [1:0][15:0] exp_tt;
  logic [1:0]       mismatch;
  logic [1:0][3:0]  fail_idx;
`endif

  int checks = 0;
  int errors = 0;

  // The function under test is whatever truth table the bench loads.
  assign fn_in[0] = tbl[0][vec[0]];
  assign fn_in[1] = tbl[1][vec[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic_tt_sweeper #(.N_IN(4), .SETTLE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort[0]), .fn_in_i(fn_in[0]),
    .vec_out_o(vec[0]), .busy_o(busy[0]), .done_o(done[0]), .tt_out_o(tt[0]),
    .tt_valid_o(tt_valid[0])
`ifdef TT_COMPARE_EN
    , .exp_tt_i(exp_tt[0]), .mismatch_o(mismatch[0]), .fail_idx_o(fail_idx[0])
`endif
  );

  logic_tt_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort[1]), .fn_in_i(fn_in[1]),
    .vec_out_o(vec[1]), .busy_o(busy[1]), .done_o(done[1]), .tt_out_o(tt[1]),
    .tt_valid_o(tt_valid[1])
`ifdef TT_COMPARE_EN
    , .exp_tt_i(exp_tt[1]), .mismatch_o(mismatch[1]), .fail_idx_o(fail_idx[1])
`endif
  );

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (vec[d] !== 4'h0) begin errors++; $display("FAIL reset_vec d%0d got %h want 0", d, vec[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d got %b want 0", d, busy[d]); end
      checks++; if (done[d] !== 1'b0) begin errors++; $display("FAIL reset_done d%0d got %b want 0", d, done[d]); end
      checks++; if (tt[d] !== 16'h0) begin errors++; $display("FAIL reset_tt d%0d got %h want 0", d, tt[d]); end
      checks++; if (tt_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid d%0d got %b want 0", d, tt_valid[d]); end
    end
  endtask

  // One full sweep: vectors step 0..15 each held SETTLE+1 cycles, done after 16*(SETTLE+1) edges.
  task automatic run_sweep(input int d, input logic [15:0] drive, input logic [15:0] expv,
                           input bit hold, input bit with_abort);
    int per, lat, bad_e;
    bit vec_bad, ctl_bad, keep_bad;
    logic [3:0] bad_v;
    per = (d == 0) ? 1 : 2;
    lat = 16 * per;
    tbl[d] = drive;
    vec_bad = 0; ctl_bad = 0; keep_bad = 0; bad_e = 0; bad_v = '0;
    @(negedge clk);
    start[d] = 1'b1;
    abort[d] = with_abort;
    @(posedge clk); #1;
    if (!hold) start[d] = 1'b0;
    abort[d] = 1'b0;
    for (int e = 0; e < lat; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (vec[d] !== 4'(e / per) && !vec_bad) begin vec_bad = 1; bad_e = e; bad_v = vec[d]; end
      if (busy[d] !== 1'b1 || done[d] !== 1'b0) ctl_bad = 1;
      if (tt[d] !== m_tt[d] || tt_valid[d] !== 1'b0) keep_bad = 1;
    end
    checks++;
    if (vec_bad) begin errors++; $display("FAIL vec_step d%0d edge %0d got %h want %h", d, bad_e, bad_v, 4'(bad_e / per)); end
    checks++;
    if (ctl_bad) begin errors++; $display("FAIL busy_during_sweep d%0d got bad busy/done want busy=1 done=0", d); end
    checks++;
    if (keep_bad) begin errors++; $display("FAIL table_held_during_sweep d%0d got tt/valid changed want %h/0", d, m_tt[d]); end
    @(posedge clk); #1;
    checks++; if (done[d] !== 1'b1) begin errors++; $display("FAIL done_latency d%0d got %b want 1 at edge %0d", d, done[d], lat); end
    checks++; if (tt[d] !== expv) begin errors++; $display("FAIL tt_out d%0d got %h want %h", d, tt[d], expv); end
    checks++; if (tt_valid[d] !== 1'b1) begin errors++; $display("FAIL tt_valid d%0d got %b want 1", d, tt_valid[d]); end
    checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL busy_at_done d%0d got %b want 0", d, busy[d]); end
    m_tt[d] = expv;
    m_valid[d] = 1'b1;
    @(posedge clk); #1;
    if (hold) start[d] = 1'b0;
    checks++; if (done[d] !== 1'b0) begin errors++; $display("FAIL done_pulse_width d%0d got %b want 0", d, done[d]); end
    checks++; if (vec[d] !== 4'h0) begin errors++; $display("FAIL vec_after_done d%0d got %h want 0", d, vec[d]); end
    checks++; if (tt[d] !== m_tt[d] || tt_valid[d] !== m_valid[d]) begin
      errors++; $display("FAIL table_hold d%0d got %h/%b want %h/%b", d, tt[d], tt_valid[d], m_tt[d], m_valid[d]);
    end
  endtask

  task automatic test_spec_functions();
    logic [15:0] t;
    logic [3:0]  x;
    for (int v = 0; v < 16; v++) begin
      x = 4'(v);
      t[v] = (x[3] & x[2] & ~x[1] & ~x[0]) | (x[3] & x[2] & x[1] & x[0]);
    end
    run_sweep(1, t, 16'h9000, 0, 0);
    run_sweep(0, 16'hFFFF, 16'hFFFF, 0, 0);
  endtask

  task automatic test_random_tables();
    logic [15:0] t;
    for (int k = 0; k < 4; k++) begin
      t = 16'($urandom());
      run_sweep(k % 2, t, t, 0, 0);
    end
  endtask

  task automatic test_abort(input int d, input logic [3:0] av);
    bit found, quiet_bad;
    tbl[d] = 16'($urandom());
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    m_valid[d] = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (vec[d] === av) begin found = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach_vec d%0d got timeout want vec %h", d, av); end
    abort[d] = 1'b1;
    @(posedge clk); #1;
    abort[d] = 1'b0;
    checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL abort_busy d%0d got %b want 0", d, busy[d]); end
    checks++; if (vec[d] !== 4'h0) begin errors++; $display("FAIL abort_vec d%0d got %h want 0", d, vec[d]); end
    checks++; if (tt[d] !== m_tt[d]) begin errors++; $display("FAIL abort_tt_kept d%0d got %h want %h", d, tt[d], m_tt[d]); end
    checks++; if (tt_valid[d] !== 1'b0) begin errors++; $display("FAIL abort_valid d%0d got %b want 0", d, tt_valid[d]); end
    quiet_bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done[d] !== 1'b0 || busy[d] !== 1'b0) quiet_bad = 1;
    end
    checks++;
    if (quiet_bad) begin errors++; $display("FAIL abort_no_done d%0d got done/busy activity want none", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] t;
    bit quiet_bad;
    t = 16'($urandom());
    run_sweep(1, t, t, 1, 0);
    quiet_bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done[1] !== 1'b0 || busy[1] !== 1'b0) quiet_bad = 1;
    end
    checks++;
    if (quiet_bad) begin errors++; $display("FAIL held_start_single_sweep got extra activity want idle"); end
    t = 16'($urandom());
    run_sweep(1, t, t, 0, 0);
  endtask

  task automatic test_start_abort_idle();
    logic [15:0] t;
    t = 16'($urandom());
    run_sweep(0, t, t, 0, 1);
  endtask

  task automatic test_reset_mid();
    tbl[1] = 16'($urandom());
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (vec[1] !== 4'h0) begin errors++; $display("FAIL rst_mid_vec got %h want 0", vec[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy[1]); end
    checks++; if (tt[1] !== 16'h0 || tt[0] !== 16'h0) begin errors++; $display("FAIL rst_mid_tt got %h/%h want 0", tt[1], tt[0]); end
    checks++; if (tt_valid !== 2'b00 || done !== 2'b00) begin errors++; $display("FAIL rst_mid_flags got valid %b done %b want 0", tt_valid, done); end
    @(negedge clk);
    rst = 1'b0;
    m_tt = '0;
    m_valid = '0;
  endtask

`ifdef TT_COMPARE_EN
  task automatic test_compare();
    logic [15:0] t, e, df;
    logic [3:0]  lo;
    logic [3:0]  x;
    for (int v = 0; v < 16; v++) begin
      x = 4'(v);
      t[v] = (x[3] & x[2] & ~x[1] & ~x[0]) | (x[3] & x[2] & x[1] & x[0]);
    end
    exp_tt[1] = 16'h9001;
    run_sweep(1, t, 16'h9000, 0, 0);
    checks++; if (mismatch[1] !== 1'b1) begin errors++; $display("FAIL cmp_mismatch got %b want 1", mismatch[1]); end
    checks++; if (fail_idx[1] !== 4'd0) begin errors++; $display("FAIL cmp_fail_idx got %0d want 0", fail_idx[1]); end
    for (int k = 0; k < 3; k++) begin
      t = 16'($urandom());
      e = (k == 0) ? t : (t ^ (16'h1 << $urandom_range(15, 1)));
      exp_tt[1] = e;
      df = t ^ e;
      lo = '0;
      for (int i = 15; i >= 0; i--) if (df[i]) lo = 4'(i);
      run_sweep(1, t, t, 0, 0);
      checks++; if (mismatch[1] !== (df != 16'h0)) begin errors++; $display("FAIL cmp_rand_mismatch got %b want %b", mismatch[1], (df != 16'h0)); end
      checks++; if (fail_idx[1] !== lo) begin errors++; $display("FAIL cmp_rand_fail_idx got %0d want %0d", fail_idx[1], lo); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = '0;
    abort = '0;
    tbl = '0;
    m_tt = '0;
    m_valid = '0;
`ifdef TT_COMPARE_EN
    exp_tt = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_spec_functions();
    test_random_tables();
    test_abort(1, 4'd7);
    test_abort(0, 4'($urandom_range(15, 0)));
    test_back_to_back();
    test_start_abort_idle();
    test_reset_mid();
`ifdef TT_COMPARE_EN
    test_compare();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
